pcf8575_access_sched: RTL and testbench
=======================================

// Module: pcf8575_access_sched
// PURPOSE
//  Schedules all accesses to one PCF8575 I/O expander through the I2C transaction engine.
//  Two client ports issue masked 16-bit output writes, arbitrated round-robin.
//  Expander INT and a refresh timer trigger 16-bit input reads.
//  Keeps the output shadow and the last-read input image; retries NACKed transfers.
// PARAMETERS
//  DEV_ADDR      3'b000  A2..A0 strap value driven on cmd_addr
//  REFRESH_CYC   100000  cycles between forced reads with no INT (>=2)
//  CNT_W         17      refresh counter width (2**CNT_W > REFRESH_CYC)
//  MAX_RETRY     2       re-issues after NACK before a command is dropped (0..7)
// PORTS
//  clk          in   1   system clock
//  rst_n        in   1   asynchronous active-low reset
//  req_a_valid  in   1   client A write request
//  req_a_mask   in   16  bits of A to update (1 = update)
//  req_a_data   in   16  new bit values for A
//  req_a_ready  out  1   1-cycle pulse: A request accepted
//  req_b_*      --   --  same four signals for client B
//  int_n        in   1   PCF8575 INT, active low, asynchronous
//  cmd_valid    out  1   command to engine
//  cmd_rd       out  1   1 = read 2 bytes, 0 = write 2 bytes
//  cmd_addr     out  3   always DEV_ADDR
//  cmd_wdata    out  16  write data, P17..P10 in [15:8], P07..P00 in [7:0]
//  cmd_ready    in   1   engine accepts a command when cmd_valid & cmd_ready
//  done         in   1   1-cycle pulse: transaction finished
//  nack         in   1   qualifies done: slave NACKed
//  rdata        in   16  read data, valid with done
//  port_out     out  16  committed output shadow
//  port_in      out  16  last successfully read input image
//  in_valid     out  1   1-cycle pulse when port_in is updated
//  err_nack     out  1   sticky: a command was dropped after MAX_RETRY
//  err_clr      in   1   clears err_nack
// BEHAVIOUR
//  Reset values: cmd_valid 0, cmd_rd 0, cmd_wdata 16'hFFFF, port_out 16'hFFFF, port_in 0,
//   in_valid 0, req_*_ready 0, err_nack 0, rd_pending 0, refresh counter 0, rr pointer = A.
//   PCF8575 outputs come out of power-up high, so 16'hFFFF is the port_out reset value.
//  Sync int_n with 2 flops. A synced falling edge sets rd_pending.
//   rd_pending is also set when the refresh counter reaches REFRESH_CYC-1.
//   Counter runs freely and returns to 0 on every successful read completion.
//  FSM IDLE -> ISSUE -> WAIT -> IDLE.
//   IDLE priority: rd_pending > client write. Between A and B, use round-robin.
//    The pointer moves past the client that was granted.
//   Grant write X: req_X_ready = 1 this cycle.
//    cmd_wdata <= (port_out & ~mask) | (data & mask); cmd_rd <= 0; retry count <= 0.
//   Grant read: clear rd_pending; cmd_rd <= 1; retry count <= 0.
//  ISSUE: cmd_valid = 1 starting the cycle after the grant.
//   cmd_valid, cmd_rd and cmd_wdata stay stable until cmd_ready. Go to WAIT on the handshake.
//  WAIT: cmd_valid = 0. Ignore rdata and nack until done.
//   done & !nack on write: port_out <= cmd_wdata; go to IDLE.
//   done & !nack on read: port_in <= rdata, in_valid = 1 next cycle; go to IDLE.
//   done & nack with retry < MAX_RETRY: retry++, back to ISSUE with the same command.
//   done & nack with retry == MAX_RETRY: drop the command, set err_nack, go to IDLE.
//    A dropped write leaves port_out unchanged.
//  Minimum spacing between commands: next grant in the IDLE cycle after done.
//   Issue follows 1 cycle after that.
//  INT edge or refresh expiry outside IDLE: rd_pending latches and is served next.
//   Multiple events coalesce into one read.
//  err_clr and a new drop in the same cycle: err_nack stays 1 (set wins).
//  A and B both valid in IDLE with rd_pending = 0: only the rr-pointed client gets ready.
//  The other client holds its request, which is served on the next IDLE.
//  rst_n low mid-transaction: all state goes to reset values at once.
//   cmd_valid drops asynchronously. The engine is reset by the same rst_n.
// TESTING
//  After reset, A writes mask FFFF data 00FF -> cmd_wdata 00FF.
//   Then done & !nack -> port_out 00FF.
//  Next, B writes mask 0F00 data 0500 -> cmd_wdata 05FF, port_out 05FF.
//  A and B valid in the same cycle, twice -> grants A, B, A, B; only one ready per grant.
//  int_n falls while A's write is in WAIT -> read issued next (cmd_rd 1).
//   rdata A5C3 -> port_in A5C3, in_valid pulses for 1 cycle.
//  MAX_RETRY 2, every done has nack -> 3 identical commands issued.
//   Then err_nack = 1 and port_out unchanged; err_clr -> err_nack 0.
//  REFRESH_CYC 50, int_n held high -> read commands 50 cycles plus transaction time apart.
//  Assert rst_n low while cmd_valid = 1 -> cmd_valid 0 and port_out FFFF immediately.

Source files
------------

// File: rtl/pcf8575_access_sched_if.sv
`default_nettype none
// ============================================================================
//  Module      : pcf8575_access_sched_if
//  Description : Command/response bus between the PCF8575 access scheduler
//                and the I2C transaction engine.
//                master : scheduler side (drives the command, receives status)
//                slave  : engine side (accepts the command, reports done/nack)
//  Signals     : cmd_valid/cmd_ready handshake, cmd_rd, cmd_addr, cmd_wdata,
//                done (1-cycle pulse), nack (qualifies done), rdata.
//  Revision    : 1.0  initial release
// ============================================================================
interface pcf8575_access_sched_if;
   logic        cmd_valid;
   logic        cmd_rd;
   logic [2:0]  cmd_addr;
   logic [15:0] cmd_wdata;
   logic        cmd_ready;
   logic        done;
   logic        nack;
   logic [15:0] rdata;

   modport master (
      output cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
      input  cmd_ready, done, nack, rdata
   );

   modport slave (
      input  cmd_valid, cmd_rd, cmd_addr, cmd_wdata,
      output cmd_ready, done, nack, rdata
   );
endinterface
`default_nettype wire

// File: rtl/pcf8575_access_sched.sv
`default_nettype none
// ============================================================================
//  Module      : pcf8575_access_sched
//  Description : Serialises every access to one PCF8575 expander through the
//                I2C transaction engine. Two clients issue masked 16-bit
//                output writes (round-robin); INT falling edges and a refresh
//                timer request 16-bit input reads, which take priority.
//                Keeps the committed output shadow and last input image, and
//                re-issues NACKed transfers up to MAX_RETRY times.
//  Ports       : clk, rst_n (async, active low)
//                req_{a,b}_valid/mask/data in, req_{a,b}_ready out (pulse)
//                int_n      expander INT, active low, asynchronous
//                eng        engine command bus (master modport)
//                port_out   committed output shadow
//                port_in    last successfully read input image
//                in_valid   pulse when port_in is updated
//                err_nack   sticky drop flag, cleared by err_clr
//  Revision    : 1.0  initial release
// ============================================================================
module pcf8575_access_sched #(
   parameter logic [2:0] DEV_ADDR    = 3'b000,
   parameter int         REFRESH_CYC = 100000,
   parameter int         CNT_W       = 17,
   parameter int         MAX_RETRY   = 2
) (
   input  wire logic        clk,
   input  wire logic        rst_n,
   input  wire logic        req_a_valid,
   input  wire logic [15:0] req_a_mask,
   input  wire logic [15:0] req_a_data,
   output logic             req_a_ready,
   input  wire logic        req_b_valid,
   input  wire logic [15:0] req_b_mask,
   input  wire logic [15:0] req_b_data,
   output logic             req_b_ready,
   input  wire logic        int_n,
   pcf8575_access_sched_if.master eng,
   output logic [15:0]      port_out,
   output logic [15:0]      port_in,
   output logic             in_valid,
   output logic             err_nack,
   input  wire logic        err_clr
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ISSUE = 2'd1;
   localparam logic [1:0] ST_WAIT  = 2'd2;

   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(REFRESH_CYC - 1);
   localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
   localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRY);

   logic [1:0]       state_q,     state_d;
   logic [2:0]       int_sync_q,  int_sync_d;
   logic             rd_pending_q, rd_pending_d;
   logic [CNT_W-1:0] cnt_q,       cnt_d;
   logic             rr_b_q,      rr_b_d;      // 1: B wins the next tie
   logic [2:0]       retry_q,     retry_d;
   logic             cmd_rd_q,    cmd_rd_d;
   logic [15:0]      cmd_wdata_q, cmd_wdata_d;
   logic [15:0]      port_out_q,  port_out_d;
   logic [15:0]      port_in_q,   port_in_d;
   logic             in_valid_q,  in_valid_d;
   logic             err_nack_q,  err_nack_d;

   logic in_idle, pick_b, grant_rd, grant_a, grant_b;
   logic done_ok, done_bad, drop, int_fall, cnt_hit;

   // int_sync_q[0..1] are the synchroniser, [2] is the previous synced value
   assign int_fall = int_sync_q[2] & ~int_sync_q[1];
   assign cnt_hit  = (cnt_q == CNT_LAST);

   // Reads always pre-empt writes; between the clients B is chosen when it
   // is the only requester or when the pointer favours it.
   assign in_idle  = (state_q == ST_IDLE);
   assign pick_b   = req_b_valid & (~req_a_valid | rr_b_q);
   assign grant_rd = in_idle & rd_pending_q;
   assign grant_a  = in_idle & ~rd_pending_q & req_a_valid & ~pick_b;
   assign grant_b  = in_idle & ~rd_pending_q & pick_b;

   // rdata and nack are meaningful only while done is high in WAIT
   assign done_ok  = (state_q == ST_WAIT) & eng.done & ~eng.nack;
   assign done_bad = (state_q == ST_WAIT) & eng.done &  eng.nack;
   assign drop     = done_bad & (retry_q == RETRY_LIMIT);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         int_sync_q   <= 3'b111;
         rd_pending_q <= 1'b0;
         cnt_q        <= '0;
         rr_b_q       <= 1'b0;
         retry_q      <= 3'd0;
         cmd_rd_q     <= 1'b0;
         cmd_wdata_q  <= 16'hFFFF;
         port_out_q   <= 16'hFFFF;
         port_in_q    <= 16'h0000;
         in_valid_q   <= 1'b0;
         err_nack_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         int_sync_q   <= int_sync_d;
         rd_pending_q <= rd_pending_d;
         cnt_q        <= cnt_d;
         rr_b_q       <= rr_b_d;
         retry_q      <= retry_d;
         cmd_rd_q     <= cmd_rd_d;
         cmd_wdata_q  <= cmd_wdata_d;
         port_out_q   <= port_out_d;
         port_in_q    <= port_in_d;
         in_valid_q   <= in_valid_d;
         err_nack_q   <= err_nack_d;
      end
   end

   // ----------------------------------------------------------- next state
   always_comb begin
      state_d      = state_q;
      int_sync_d   = {int_sync_q[1:0], int_n};
      cnt_d        = cnt_q + CNT_ONE;
      rr_b_d       = rr_b_q;
      retry_d      = retry_q;
      cmd_rd_d     = cmd_rd_q;
      cmd_wdata_d  = cmd_wdata_q;
      port_out_d   = port_out_q;
      port_in_d    = port_in_q;
      in_valid_d   = 1'b0;
      // Events arriving while busy (or in the grant cycle) stay latched
      rd_pending_d = (rd_pending_q & ~grant_rd) | int_fall | cnt_hit;
      err_nack_d   = drop | (err_nack_q & ~err_clr);

      if (cnt_hit || (done_ok && cmd_rd_q)) begin
         cnt_d = '0;
      end

      case (state_q)
         ST_IDLE: begin
            if (grant_rd) begin
               cmd_rd_d = 1'b1;
               retry_d  = 3'd0;
               state_d  = ST_ISSUE;
            end else if (grant_a) begin
               cmd_rd_d    = 1'b0;
               cmd_wdata_d = (port_out_q & ~req_a_mask) | (req_a_data & req_a_mask);
               retry_d     = 3'd0;
               rr_b_d      = 1'b1;
               state_d     = ST_ISSUE;
            end else if (grant_b) begin
               cmd_rd_d    = 1'b0;
               cmd_wdata_d = (port_out_q & ~req_b_mask) | (req_b_data & req_b_mask);
               retry_d     = 3'd0;
               rr_b_d      = 1'b0;
               state_d     = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (eng.cmd_ready) begin
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (done_ok) begin
               if (cmd_rd_q) begin
                  port_in_d  = eng.rdata;
                  in_valid_d = 1'b1;
               end else begin
                  port_out_d = cmd_wdata_q;
               end
               state_d = ST_IDLE;
            end else if (drop) begin
               state_d = ST_IDLE;
            end else if (done_bad) begin
               retry_d = retry_q + 3'd1;
               state_d = ST_ISSUE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      eng.cmd_valid = (state_q == ST_ISSUE);
      eng.cmd_rd    = cmd_rd_q;
      eng.cmd_addr  = DEV_ADDR;
      eng.cmd_wdata = cmd_wdata_q;
      req_a_ready   = grant_a;
      req_b_ready   = grant_b;
      port_out      = port_out_q;
      port_in       = port_in_q;
      in_valid      = in_valid_q;
      err_nack      = err_nack_q;
   end

endmodule
`default_nettype wire

// File: tb/tb_pcf8575_access_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pcf8575_access_sched
//  Description : Self-checking bench for pcf8575_access_sched. A behavioural
//                engine answers commands and logs them; a transaction-level
//                model predicts the log, port_out, port_in and err_nack.
//                A second instance with a short refresh period is used to
//                check the forced-read spacing.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pcf8575_access_sched;

   localparam logic [2:0] ADDR = 3'b101;
   localparam int         MAXR = 2;
   localparam int         REF2 = 50;

   typedef struct packed {
      logic        rd;
      logic [15:0] wdata;
      logic [2:0]  addr;
   } cmd_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0, rst2_n = 1'b0;
   logic        req_a_valid = 0, req_b_valid = 0;
   logic [15:0] req_a_mask = 0, req_a_data = 0, req_b_mask = 0, req_b_data = 0;
   logic        req_a_ready, req_b_ready;
   logic        int_n = 1'b1;
   logic [15:0] port_out, port_in;
   logic        in_valid, err_nack;
   logic        err_clr = 1'b0;

   logic        r2_a_ready, r2_b_ready, in_valid2, err_nack2;
   logic [15:0] port_out2, port_in2;

   pcf8575_access_sched_if bus ();
   pcf8575_access_sched_if bus2 ();

   pcf8575_access_sched #(.DEV_ADDR(ADDR), .REFRESH_CYC(4000), .CNT_W(12), .MAX_RETRY(MAXR)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a_valid(req_a_valid), .req_a_mask(req_a_mask), .req_a_data(req_a_data), .req_a_ready(req_a_ready),
      .req_b_valid(req_b_valid), .req_b_mask(req_b_mask), .req_b_data(req_b_data), .req_b_ready(req_b_ready),
      .int_n(int_n), .eng(bus), .port_out(port_out), .port_in(port_in),
      .in_valid(in_valid), .err_nack(err_nack), .err_clr(err_clr)
   );

   pcf8575_access_sched #(.DEV_ADDR(3'b000), .REFRESH_CYC(REF2), .CNT_W(6), .MAX_RETRY(MAXR)) dut2 (
      .clk(clk), .rst_n(rst2_n),
      .req_a_valid(1'b0), .req_a_mask(16'h0), .req_a_data(16'h0), .req_a_ready(r2_a_ready),
      .req_b_valid(1'b0), .req_b_mask(16'h0), .req_b_data(16'h0), .req_b_ready(r2_b_ready),
      .int_n(1'b1), .eng(bus2), .port_out(port_out2), .port_in(port_in2),
      .in_valid(in_valid2), .err_nack(err_nack2), .err_clr(1'b0)
   );

   int n_tests = 0, n_fail = 0;
   int done_cnt = 0, inv_cnt = 0, cyc = 0;
   int nack_budget = 0, eng_lat_min = 1, eng_lat_max = 4;
   bit eng_en = 1'b1;
   logic [15:0] eng_rdata = 16'h0;
   cmd_t log_q[$];
   int h2_q[$], d2_q[$];
   bit rd2_q[$];

   // transaction-level reference state
   logic [15:0] ref_out = 16'hFFFF, ref_in = 16'h0;
   bit ref_err = 1'b0, ref_rr_b = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk); #1;
   endtask

   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) if (rst_n && in_valid === 1'b1) inv_cnt <= inv_cnt + 1;

   // behavioural I2C engine for the main instance
   initial begin : p_engine
      cmd_t cur;
      int   st;
      bus.cmd_ready = 0; bus.done = 0; bus.nack = 0; bus.rdata = 0;
      forever begin
         @(negedge clk);
         if (eng_en && rst_n && bus.cmd_valid === 1'b1) begin
            cur = '{rd: bus.cmd_rd, wdata: bus.cmd_wdata, addr: bus.cmd_addr};
            st  = $urandom_range(0, 2);
            repeat (st) begin
               @(negedge clk);
               chk("cmd_stable", {11'd0, bus.cmd_valid, bus.cmd_rd, bus.cmd_wdata, bus.cmd_addr},
                   {11'd0, 1'b1, cur.rd, cur.wdata, cur.addr});
            end
            bus.cmd_ready = 1'b1;
            @(posedge clk); #1;
            bus.cmd_ready = 1'b0;
            log_q.push_back(cur);
            repeat ($urandom_range(eng_lat_min, eng_lat_max) - 1) begin
               bus.nack = 1'($urandom); bus.rdata = 16'($urandom);
               @(posedge clk); #1;
            end
            bus.done  = 1'b1;
            bus.nack  = (nack_budget > 0);
            bus.rdata = eng_rdata;
            if (nack_budget > 0) nack_budget--;
            @(posedge clk); #1;
            bus.done = 1'b0; bus.nack = 1'b0;
            done_cnt++;
         end
      end
   end

   // always-ready engine for the refresh instance, done 3 cycles after handshake
   initial begin : p_engine2
      bus2.cmd_ready = 1'b1; bus2.done = 0; bus2.nack = 0; bus2.rdata = 16'h1234;
      forever begin
         @(negedge clk);
         if (rst2_n && bus2.cmd_valid === 1'b1) begin
            h2_q.push_back(cyc);
            rd2_q.push_back(bus2.cmd_rd);
            repeat (3) @(posedge clk);
            #1;
            d2_q.push_back(cyc);
            bus2.done = 1'b1;
            @(posedge clk); #1;
            bus2.done = 1'b0;
         end
      end
   end

   task automatic wait_done(input int target, input string tag);
      int cy = 0;
      while (done_cnt < target && cy < 400) begin tick(); cy++; end
      chk({tag, "_done_reached"}, 32'(done_cnt >= target), 32'd1);
      repeat (2) tick();
   endtask

   task automatic check_cmds(input int base, input int n, input bit rd, input logic [15:0] wd,
                             input string tag);
      for (int i = 0; i < n; i++) begin
         if (base + i < log_q.size()) begin
            chk({tag, "_rd"}, 32'(log_q[base+i].rd), 32'(rd));
            chk({tag, "_addr"}, 32'(log_q[base+i].addr), 32'(ADDR));
            if (!rd) chk({tag, "_wdata"}, 32'(log_q[base+i].wdata), 32'(wd));
         end
      end
   endtask

   task automatic client_wr(input bit is_b, input logic [15:0] m, input logic [15:0] d);
      bit got = 0;
      if (is_b) begin req_b_valid = 1; req_b_mask = m; req_b_data = d; end
      else      begin req_a_valid = 1; req_a_mask = m; req_a_data = d; end
      for (int cy = 0; cy < 200 && !got; cy++) begin
         @(negedge clk);
         got = is_b ? req_b_ready : req_a_ready;
      end
      chk("client_granted", 32'(got), 32'd1);
      tick();
      req_a_valid = 0; req_b_valid = 0;
      ref_rr_b = !is_b;
   endtask

   task automatic clear_err(input string tag);
      err_clr = 1; tick(); err_clr = 0; tick();
      ref_err = 0;
      chk({tag, "_err_cleared"}, 32'(err_nack), 32'd0);
   endtask

   task automatic write_op(input bit is_b, input logic [15:0] m, input logic [15:0] d,
                           input int k, input string tag);
      logic [15:0] wd;
      int base, dc, n;
      wd = (ref_out & ~m) | (d & m);
      n = (k > MAXR) ? MAXR + 1 : k + 1;
      base = log_q.size(); dc = done_cnt; nack_budget = k;
      client_wr(is_b, m, d);
      wait_done(dc + n, tag);
      chk({tag, "_ncmd"}, 32'(log_q.size()), 32'(base + n));
      check_cmds(base, n, 1'b0, wd, tag);
      if (k <= MAXR) ref_out = wd; else ref_err = 1;
      chk({tag, "_port_out"}, 32'(port_out), 32'(ref_out));
      chk({tag, "_err"}, 32'(err_nack), 32'(ref_err));
      if (ref_err) clear_err(tag);
   endtask

   task automatic read_op(input int k, input logic [15:0] r, input string tag);
      int base, dc, n, iv;
      n = (k > MAXR) ? MAXR + 1 : k + 1;
      base = log_q.size(); dc = done_cnt; iv = inv_cnt;
      eng_rdata = r; nack_budget = k;
      int_n = 0; repeat (3) tick(); int_n = 1;
      wait_done(dc + n, tag);
      chk({tag, "_ncmd"}, 32'(log_q.size()), 32'(base + n));
      check_cmds(base, n, 1'b1, 16'h0, tag);
      if (k <= MAXR) ref_in = r; else ref_err = 1;
      chk({tag, "_port_in"}, 32'(port_in), 32'(ref_in));
      chk({tag, "_in_valid_pulses"}, 32'(inv_cnt - iv), 32'((k <= MAXR) ? 1 : 0));
      chk({tag, "_err"}, 32'(err_nack), 32'(ref_err));
      if (ref_err) clear_err(tag);
   endtask

   task automatic both_op(input logic [15:0] ma, input logic [15:0] da,
                          input logic [15:0] mb, input logic [15:0] db, input string tag);
      bit a_p = 1, b_p = 1, ga, gb, both = 0, first_b;
      bit g[$];
      int base, dc;
      logic [15:0] w1, w2;
      base = log_q.size(); dc = done_cnt;
      first_b = ref_rr_b;
      req_a_valid = 1; req_a_mask = ma; req_a_data = da;
      req_b_valid = 1; req_b_mask = mb; req_b_data = db;
      for (int cy = 0; cy < 300 && (a_p || b_p); cy++) begin
         @(negedge clk);
         ga = req_a_ready; gb = req_b_ready;
         if (ga && gb) both = 1;
         tick();
         if (ga) begin req_a_valid = 0; a_p = 0; g.push_back(1'b0); end
         if (gb) begin req_b_valid = 0; b_p = 0; g.push_back(1'b1); end
      end
      req_a_valid = 0; req_b_valid = 0;
      chk({tag, "_one_ready"}, 32'(both), 32'd0);
      chk({tag, "_ngrants"}, 32'(g.size()), 32'd2);
      if (g.size() == 2) begin
         chk({tag, "_grant0"}, 32'(g[0]), 32'(first_b));
         chk({tag, "_grant1"}, 32'(g[1]), 32'(!first_b));
      end
      w1 = first_b ? ((ref_out & ~mb) | (db & mb)) : ((ref_out & ~ma) | (da & ma));
      w2 = first_b ? ((w1 & ~ma) | (da & ma)) : ((w1 & ~mb) | (db & mb));
      ref_out = w2;
      ref_rr_b = first_b;   // second grant went to the other client
      wait_done(dc + 2, tag);
      check_cmds(base, 1, 1'b0, w1, {tag, "_c1"});
      check_cmds(base + 1, 1, 1'b0, w2, {tag, "_c2"});
      chk({tag, "_port_out"}, 32'(port_out), 32'(ref_out));
   endtask

   task automatic do_reset();
      rst_n = 0; repeat (2) tick(); rst_n = 1; tick();
      ref_out = 16'hFFFF; ref_in = 16'h0; ref_err = 0; ref_rr_b = 0;
   endtask

   initial begin : p_watchdog
      #500000;
      $display("FAIL watchdog expired n_tests=%0d", n_tests);
      $fatal(1, "watchdog");
   end

   initial begin : p_main
      int base, dc, iv, op, k;
      logic [15:0] wd;
      bit seen;
      repeat (2) tick();
      rst2_n = 1;
      do_reset();

      // reset values
      chk("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
      chk("rst_cmd_rd", 32'(bus.cmd_rd), 32'd0);
      chk("rst_cmd_wdata", 32'(bus.cmd_wdata), 32'hFFFF);
      chk("rst_cmd_addr", 32'(bus.cmd_addr), 32'(ADDR));
      chk("rst_port_out", 32'(port_out), 32'hFFFF);
      chk("rst_port_in", 32'(port_in), 32'h0);
      chk("rst_in_valid", 32'(in_valid), 32'd0);
      chk("rst_readies", {30'd0, req_a_ready, req_b_ready}, 32'd0);
      chk("rst_err", 32'(err_nack), 32'd0);

      // directed writes from both clients
      write_op(1'b0, 16'hFFFF, 16'h00FF, 0, "wrA");
      chk("wrA_const", 32'(port_out), 32'h00FF);
      write_op(1'b1, 16'h0F00, 16'h0500, 0, "wrB");
      chk("wrB_const", 32'(port_out), 32'h05FF);

      // simultaneous requests, twice
      both_op(16'h00F0, 16'h0030, 16'h000F, 16'h0009, "both1");
      both_op(16'hF000, 16'h3000, 16'h0F00, 16'h0C00, "both2");

      // INT falls while a write is in flight: the read follows it
      eng_lat_min = 8; eng_lat_max = 8; nack_budget = 0;
      base = log_q.size(); dc = done_cnt; iv = inv_cnt;
      wd = 16'h0F0F;
      client_wr(1'b0, 16'hFFFF, 16'h0F0F);
      for (int cy = 0; cy < 100 && log_q.size() == base; cy++) tick();
      int_n = 0; eng_rdata = 16'hA5C3;
      repeat (3) tick();
      int_n = 1;
      wait_done(dc + 2, "intw");
      eng_lat_min = 1; eng_lat_max = 4;
      ref_out = wd; ref_in = 16'hA5C3;
      chk("intw_ncmd", 32'(log_q.size()), 32'(base + 2));
      check_cmds(base, 1, 1'b0, wd, "intw_wr");
      check_cmds(base + 1, 1, 1'b1, 16'h0, "intw_rd");
      chk("intw_port_in", 32'(port_in), 32'hA5C3);
      chk("intw_in_valid_pulses", 32'(inv_cnt - iv), 32'd1);
      chk("intw_port_out", 32'(port_out), 32'(ref_out));

      // every attempt NACKed: three identical commands, then dropped
      write_op(1'b0, 16'h00FF, 16'h0042, 3, "retry_drop");

      // randomized mix
      do_reset();
      for (int it = 0; it < 40; it++) begin
         op = $urandom_range(0, 3);
         k  = $urandom_range(0, 3);
         case (op)
            0: write_op(1'b0, 16'($urandom), 16'($urandom), k, "rndA");
            1: write_op(1'b1, 16'($urandom), 16'($urandom), k, "rndB");
            2: both_op(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), "rndAB");
            default: read_op(k, 16'($urandom), "rndRd");
         endcase
      end

      // reset in the middle of a command
      write_op(1'b0, 16'hFFFF, 16'h1234, 0, "pre_rst");
      eng_en = 0;
      req_a_valid = 1; req_a_mask = 16'hFFFF; req_a_data = 16'h0000;
      seen = 0;
      for (int cy = 0; cy < 50 && !seen; cy++) begin
         @(negedge clk);
         seen = (bus.cmd_valid === 1'b1);
      end
      chk("rst_mid_valid_seen", 32'(seen), 32'd1);
      rst_n = 0;
      #1;
      chk("rst_mid_cmd_valid", 32'(bus.cmd_valid), 32'd0);
      chk("rst_mid_port_out", 32'(port_out), 32'hFFFF);
      chk("rst_mid_cmd_wdata", 32'(bus.cmd_wdata), 32'hFFFF);
      req_a_valid = 0;
      tick();
      rst_n = 1;
      eng_en = 1;
      tick();
      ref_out = 16'hFFFF; ref_in = 16'h0; ref_err = 0; ref_rr_b = 0;

      // refresh spacing on the short-period instance
      for (int cy = 0; cy < 1000 && d2_q.size() < 5; cy++) tick();
      chk("ref_count", 32'(d2_q.size() >= 5), 32'd1);
      for (int i = 0; i < h2_q.size(); i++) chk("ref_is_read", 32'(rd2_q[i]), 32'd1);
      for (int i = 1; i < h2_q.size() && i < d2_q.size(); i++)
         chk("ref_spacing", 32'(h2_q[i] - d2_q[i-1]), 32'(REF2 + 2));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
